// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use stall controller for the 5-stage pipeline.
// Shadows dst/control metadata through ID/EX (p0), EX/MEM (p1) and MEM/WB (p2).
module fwd_hazard_ctrl #(
   parameter int REG_BITS = 5,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pipe_hold,
   input  logic                flush,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic [REG_BITS-1:0] id_dst,
   input  logic                id_reg_write,
   input  logic                id_mem_read,
   output logic [1:0]          fwd_a_sel,
   output logic [1:0]          fwd_b_sel,
   output logic                stall,
   output logic [CNT_BITS-1:0] stall_count
);

   localparam logic [1:0] SEL_RF    = 2'b00;
   localparam logic [1:0] SEL_MEMWB = 2'b01;
   localparam logic [1:0] SEL_EXMEM = 2'b10;

   logic [REG_BITS-1:0] idex_dst_p0;
   logic                idex_rw_p0;
   logic                idex_mr_p0;
   logic [REG_BITS-1:0] exmem_dst_p1;
   logic                exmem_rw_p1;
   logic                exmem_mr_p1;
   logic [REG_BITS-1:0] memwb_dst_p2;
   logic                memwb_rw_p2;

   logic                idex_live;
   logic                exmem_live;
   logic [1:0]          sel_a_nxt;
   logic [1:0]          sel_b_nxt;

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Nearer stage wins; the MEM/WB entry is covered by write-before-read in the register file.
   function automatic logic [1:0] pick_sel(input logic [REG_BITS-1:0] src,
                                           input logic                idex_ok,
                                           input logic                exmem_ok);
      if (idex_ok && idex_dst_p0 == src)
         return SEL_EXMEM;
      else if (exmem_ok && exmem_dst_p1 == src)
         return SEL_MEMWB;
      else
         return SEL_RF;
   endfunction

   assign idex_live  = idex_rw_p0  && (idex_dst_p0  != '0);
   assign exmem_live = exmem_rw_p1 && (exmem_dst_p1 != '0);

   assign stall = !pipe_hold && !flush && idex_mr_p0 && idex_live &&
                  ((idex_dst_p0 == id_rs) || (idex_dst_p0 == id_rt));

   always_comb begin
      sel_a_nxt = pick_sel(id_rs, idex_live, exmem_live);
      sel_b_nxt = pick_sel(id_rt, idex_live, exmem_live);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_dst_p0  <= '0;
         idex_rw_p0   <= 1'b0;
         idex_mr_p0   <= 1'b0;
         exmem_dst_p1 <= '0;
         exmem_rw_p1  <= 1'b0;
         exmem_mr_p1  <= 1'b0;
         memwb_dst_p2 <= '0;
         memwb_rw_p2  <= 1'b0;
         fwd_a_sel    <= SEL_RF;
         fwd_b_sel    <= SEL_RF;
         stall_count  <= '0;
      end else if (!pipe_hold) begin
         // EX/MEM -> MEM/WB stage boundary
         memwb_dst_p2 <= exmem_dst_p1;
         memwb_rw_p2  <= exmem_rw_p1;
         // ID/EX -> EX/MEM stage boundary
         exmem_dst_p1 <= idex_dst_p0;
         exmem_rw_p1  <= idex_rw_p0;
         exmem_mr_p1  <= idex_mr_p0;
         // ID -> ID/EX stage boundary
         if (stall || flush) begin
            idex_dst_p0 <= '0;
            idex_rw_p0  <= 1'b0;
            idex_mr_p0  <= 1'b0;
            fwd_a_sel   <= SEL_RF;
            fwd_b_sel   <= SEL_RF;
         end else begin
            idex_dst_p0 <= id_dst;
            idex_rw_p0  <= id_reg_write;
            idex_mr_p0  <= id_mem_read;
            fwd_a_sel   <= sel_a_nxt;
            fwd_b_sel   <= sel_b_nxt;
         end
         if (stall)
            stall_count <= sat_inc(stall_count);
      end
   end

   // A load must never be picked from EX/MEM; MEM/WB simply follows EX/MEM.
   a_no_load_exmem: assert property (@(posedge clk) disable iff (rst)
      !((fwd_a_sel == SEL_EXMEM || fwd_b_sel == SEL_EXMEM) && exmem_mr_p1));
   a_memwb_follow: assert property (@(posedge clk) disable iff (rst)
      !pipe_hold |=> (memwb_dst_p2 == $past(exmem_dst_p1) && memwb_rw_p2 == $past(exmem_rw_p1)));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with a 4-bit stall counter to reach saturation.
module tb_fwd_hazard_ctrl;

   localparam int RB = 5;
   localparam int CB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          pipe_hold;
   logic          flush;
   logic [RB-1:0] id_rs;
   logic [RB-1:0] id_rt;
   logic [RB-1:0] id_dst;
   logic          id_reg_write;
   logic          id_mem_read;
   logic [1:0]    fwd_a_sel;
   logic [1:0]    fwd_b_sel;
   logic          stall;
   logic [CB-1:0] stall_count;

   int tests = 0;
   int fails = 0;
   int exp_cnt;

   fwd_hazard_ctrl #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
      .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .flush(flush),
      .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall(stall), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id(input int rs, input int rt, input int dst, input bit rw, input bit mr);
      id_rs        = RB'(rs);
      id_rt        = RB'(rt);
      id_dst       = RB'(dst);
      id_reg_write = rw;
      id_mem_read  = mr;
      #1;
   endtask

   task automatic drain();
      id(0, 0, 0, 0, 0);
      repeat (3) tick();
   endtask

   initial begin
      // Reset held across edges with random ID inputs
      rst = 1'b1; pipe_hold = 1'b0; flush = 1'b0;
      id($urandom_range(31), $urandom_range(31), $urandom_range(31), 1'b1, 1'b1);
      #2;
      chk("rst_sel_a", fwd_a_sel, 2'b00);
      chk("rst_stall", stall, 1'b0);
      repeat (2) begin
         id($urandom_range(31), $urandom_range(31), $urandom_range(31), 1'($urandom), 1'($urandom));
         tick();
      end
      chk("rst_hold_sel_a", fwd_a_sel, 2'b00);
      chk("rst_hold_sel_b", fwd_b_sel, 2'b00);
      chk("rst_hold_stall", stall, 1'b0);
      chk("rst_hold_cnt", stall_count, 0);
      id(0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();

      // add r3 ; sub rs=3 rt=4 ; reader of r3 one later
      id(1, 2, 3, 1, 0); tick();
      id(3, 4, 6, 1, 0);
      chk("alu_no_stall", stall, 1'b0);
      tick();
      chk("fwd_exmem_a", fwd_a_sel, 2'b10);
      chk("fwd_exmem_b", fwd_b_sel, 2'b00);
      id(0, 3, 8, 1, 0); tick();
      chk("fwd_memwb_a", fwd_a_sel, 2'b00);
      chk("fwd_memwb_b", fwd_b_sel, 2'b01);
      drain();

      // lw r5 ; add rs=5 rt=5
      id(0, 0, 5, 1, 1); tick();
      id(5, 5, 9, 1, 0);
      chk("lu_stall", stall, 1'b1);
      tick();
      chk("lu_cnt", stall_count, 1);
      chk("lu_stall_once", stall, 1'b0);
      chk("lu_bubble_a", fwd_a_sel, 2'b00);
      chk("lu_bubble_b", fwd_b_sel, 2'b00);
      tick();
      chk("lu_fwd_a", fwd_a_sel, 2'b01);
      chk("lu_fwd_b", fwd_b_sel, 2'b01);
      drain();

      // Two writers of r7, then a reader: nearer stage wins
      id(0, 0, 7, 1, 0); tick();
      id(0, 0, 7, 1, 0); tick();
      id(7, 1, 10, 1, 0); tick();
      chk("prio_a", fwd_a_sel, 2'b10);
      chk("prio_b", fwd_b_sel, 2'b00);
      drain();

      // r0 never forwards or stalls
      id(0, 0, 0, 1, 0); tick();
      id(0, 0, 11, 1, 0); tick();
      chk("r0_a", fwd_a_sel, 2'b00);
      chk("r0_b", fwd_b_sel, 2'b00);
      drain();
      id(0, 0, 0, 1, 1); tick();
      id(0, 0, 12, 1, 0);
      chk("r0_lw_stall", stall, 1'b0);
      drain();

      // Flush beats the hazard
      id(0, 0, 2, 1, 1); tick();
      id(2, 0, 12, 1, 0); flush = 1'b1; #1;
      chk("flush_stall", stall, 1'b0);
      tick();
      flush = 1'b0; #1;
      chk("flush_cnt", stall_count, 1);
      chk("flush_bubble", stall, 1'b0);
      drain();

      // Hold freezes a pending hazard for three cycles
      id(0, 0, 1, 1, 0); tick();
      id(1, 0, 2, 1, 1); tick();
      chk("hold_pre_a", fwd_a_sel, 2'b10);
      id(2, 0, 13, 1, 0); pipe_hold = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         chk("hold_stall", stall, 1'b0);
         tick();
         chk("hold_sel_a", fwd_a_sel, 2'b10);
         chk("hold_cnt", stall_count, 1);
      end
      pipe_hold = 1'b0; #1;
      chk("release_stall", stall, 1'b1);
      tick();
      chk("release_cnt", stall_count, 2);
      chk("release_stall_once", stall, 1'b0);
      chk("release_bubble_a", fwd_a_sel, 2'b00);
      tick();
      chk("release_fwd_a", fwd_a_sel, 2'b01);
      chk("release_fwd_b", fwd_b_sel, 2'b00);
      drain();

      // Reset in the middle of a stall
      id(0, 0, 5, 1, 1); tick();
      id(5, 0, 14, 1, 0);
      chk("mid_stall", stall, 1'b1);
      rst = 1'b1; #1;
      chk("mid_rst_stall", stall, 1'b0);
      chk("mid_rst_cnt", stall_count, 0);
      rst = 1'b0; #1;
      chk("post_rst_stall", stall, 1'b0);
      tick();
      chk("post_rst_a", fwd_a_sel, 2'b00);
      chk("post_rst_cnt", stall_count, 0);

      // 2^CB + 5 load-use stalls saturate the counter
      exp_cnt = 0;
      for (int n = 0; n < (1 << CB) + 5; n++) begin
         id(0, 0, 5, 1, 1); tick();
         id(0, 5, 15, 1, 0);
         chk("sat_stall", stall, 1'b1);
         tick();
         exp_cnt = (exp_cnt == (1 << CB) - 1) ? exp_cnt : exp_cnt + 1;
         chk("sat_cnt", stall_count, exp_cnt);
      end
      chk("sat_final", stall_count, 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Sequencing controller for the two 3:1 32-bit operand-forwarding multiplexers at the ALU inputs of the 5-stage pipeline.
- Tracks destination-register and control metadata through ID/EX, EX/MEM and MEM/WB shadow stages.
- Drives registered select codes for both operand muxes.
- Raises a load-use stall and keeps a saturating stall counter for performance debug.

Parameters:
- REG_BITS, 5, register-index width.
- CNT_BITS, 16, stall counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pipe_hold  input  1  global freeze (e.g. memory wait); all internal state holds.
- flush  input  1  instruction currently in ID is squashed.
- id_rs  input  REG_BITS  source A of the instruction in ID.
- id_rt  input  REG_BITS  source B of the instruction in ID.
- id_dst  input  REG_BITS  destination of the instruction in ID.
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- fwd_a_sel  output  2  select for the ALU operand-A mux.
- fwd_b_sel  output  2  select for the ALU operand-B mux.
- stall  output  1  hold PC and IF/ID; ID/EX receives a bubble.
- stall_count  output  CNT_BITS  number of load-use stall cycles.

Behaviour:
- Select encoding (fixed):
  - 00 = register-file operand carried in ID/EX.
  - 01 = MEM/WB writeback value.
  - 10 = EX/MEM ALU result.
  - 11 is never driven.
- Shadow stages:
  - IDEX = {dst, reg_write, mem_read}.
  - EXMEM = {dst, reg_write, mem_read}.
  - MEMWB = {dst, reg_write}.
- Reset (async, immediate):
  - All shadow fields cleared; a cleared entry acts as a bubble.
  - fwd_a_sel = fwd_b_sel = 00, stall = 0, stall_count = 0.
- stall (combinational):
  - stall = !pipe_hold && !flush && IDEX.mem_read && IDEX.reg_write && IDEX.dst != 0 && (IDEX.dst == id_rs || IDEX.dst == id_rt).
- Advance: on each rising clk with pipe_hold = 0:
  - EXMEM <= IDEX.
  - MEMWB <= EXMEM (mem_read dropped).
  - IDEX <= bubble if stall or flush; otherwise {id_dst, id_reg_write, id_mem_read}.
- Select computation, registered alongside IDEX so it is valid while that instruction is in EX. For operand A, compare id_rs against the current stage contents:
  - If IDEX.reg_write && IDEX.dst != 0 && IDEX.dst == id_rs → 10 (that instruction is moving to EX/MEM).
  - Else if EXMEM.reg_write && EXMEM.dst != 0 && EXMEM.dst == id_rs → 01 (moving to MEM/WB).
  - Else → 00.
  - Operand B is identical, using id_rt.
  - The nearer stage always wins when both match.
- On stall or flush, both selects load 00.
- A match against the current MEMWB entry is not forwarded. The register file is write-before-read within a cycle, so the ID read already returns the new value.
- Register 0 never forwards, even when reg_write = 1.
- A load result is never selected with 10: the load-use stall inserts exactly one bubble. On the following advance the load sits in EXMEM, so the held instruction gets 01.
- stall_count:
  - Increments on each rising clk where stall = 1.
  - Saturates at all-ones; no wrap.
- pipe_hold = 1:
  - All shadow registers, selects and stall_count hold.
  - stall reads 0.
  - A pending hazard re-evaluates when hold releases.
- flush = 1 together with a hazard:
  - flush wins: stall = 0, no count, bubble into IDEX.
- Reset asserted mid-stall:
  - Outputs go to reset values immediately.
  - The first post-reset cycle sees empty stages, so no forwarding and no stall.
- Back-to-back hazards (load then dependent load then dependent ALU op) each produce exactly one stall cycle.

Test Plan:
- Reset with random inputs → sel 00/00, stall 0, stall_count 0, also while rst is held high across clock edges.
- add r3 (reg_write, dst 3), then sub reading rs = 3, rt = 4 → sub in EX with fwd_a_sel = 10, fwd_b_sel = 00; one instruction later, a reader of r3 gets 01.
- lw r5, then add rs = 5, rt = 5 → stall = 1 for exactly one cycle, stall_count = 1; next EX cycle shows bubble sel 00, then add with fwd_a_sel = fwd_b_sel = 01.
- Writes to r7 in both IDEX and EXMEM, reader of r7 → 10 (priority); writer with dst 0 followed by a reader of r0 → 00 and no stall for an lw to r0.
- lw r2 and dependent instruction present with flush = 1 → stall 0, count unchanged, IDEX bubble; same hazard with pipe_hold = 1 for 3 cycles → state frozen, stall 0; on release, stall 1 for one cycle.
- Force 2^CNT_BITS + 5 load-use stalls (CNT_BITS = 4 override) → stall_count saturates at 15.
